bus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one board-level bus resource (e.g. a 74xx-built shared memory/IO path) between N_REQ requesters.
- Grants are registered one-hot and held while the owner keeps its request high.
- One dead "turnaround" cycle is inserted between owners, mirroring bus-driver switch time.
- Sits between the requester logic and the tri-state/NOR-gated bus enables.

---
 rtl/bus_rr_arbiter_pkg.sv | 13 +
 rtl/bus_rr_arbiter_rr_pick.sv | 32 +++
 rtl/bus_rr_arbiter.sv | 105 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and widths for the round-robin bus arbiter and its priority finder.
package bus_rr_arbiter_pkg;

  localparam int unsigned ID_W   = 3;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotate-priority finder: first set req bit after 'last', wrapping.
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             found,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W-1:0]  pos;
  logic [N_REQ-1:0] rot;

  // Scan last+1 .. last+N_REQ; the final candidate is 'last' itself.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    rot    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      pos = ID_W'((32'(last) + i) % N_REQ);
      rot = req >> pos;
      if (!found && rot[0]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and a one-cycle turnaround gap.
// Hold-limit preemption and the expired pulse are enabled by defining ARB_TIMEOUT_EN.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             expired
);

  arb_state_e        state, state_d;
  logic [N_REQ-1:0]  grant_d;
  logic [ID_W-1:0]   grant_id_d;
  logic              busy_d;
  logic              expired_d;
  logic [ID_W-1:0]   last, last_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              found;
  logic [ID_W-1:0]   winner;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .last   (last),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      last     <= ID_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      busy     <= busy_d;
      expired  <= expired_d;
      last     <= last_d;
      hold_cnt <= hold_d;
    end
  end

  // Next-state and next-output logic; IDLE and GAP both arbitrate at their end.
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    grant_id_d = grant_id;
    busy_d     = busy;
    expired_d  = 1'b0;
    last_d     = last;
    hold_d     = hold_cnt;
    case (state)
      ST_IDLE, ST_GAP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (found) begin
          grant_d    = N_REQ'(1) << winner;
          grant_id_d = winner;
          busy_d     = 1'b1;
          last_d     = winner;
          hold_d     = HOLD_W'(1);
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Owner release wins over the hold limit, so a coincident drop is not "expired".
        if (!(|(req & grant))) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_GAP;
        end
`ifdef ARB_TIMEOUT_EN
        else if ((hold_cnt == HOLD_W'(MAX_HOLD)) && (|(req & ~grant))) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          expired_d = 1'b1;
          state_d   = ST_GAP;
        end
`endif
        else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed plan scenarios plus randomized traffic
// against an owner/pointer reference model. Honours ARB_TIMEOUT_EN like the design.
module tb_bus_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       expired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = bus free), rotation pointer, hold count.
  int m_owner, m_hold, m_last, m_gid;
  bit m_exp;

  bus_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic [3:0] r, input logic rs);
    logic [3:0] sh;
    logic [3:0] others;
    if (rs) begin
      m_owner = -1; m_hold = 0; m_last = N - 1; m_gid = 0; m_exp = 1'b0;
      return;
    end
    m_exp = 1'b0;
    if (m_owner >= 0) begin
      sh     = r >> m_owner;
      others = r & ~(4'b0001 << m_owner);
      if (!sh[0]) m_owner = -1;
      else if (TO_EN && m_hold == MH && others != 4'b0000) begin
        m_owner = -1;
        m_exp   = 1'b1;
      end else if (m_hold < MH) m_hold++;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c  = (m_last + k) % N;
        sh = r >> c;
        if (sh[0]) begin
          m_owner = c; m_gid = c; m_last = c; m_hold = 1;
          break;
        end
      end
    end
  endfunction

  function automatic logic [3:0] m_grant();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic test_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired: got %b expected 0", expired); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
  endtask

  task automatic test_single();
    step(4'b0001, 1'b0);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", grant); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", grant_id); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    step(4'b0000, 1'b0);
    n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant=%b busy=%b expected 0000/0", grant, busy); end
  endtask

  task automatic test_rotation();
    logic [3:0] cur;
    logic [3:0] exp_g;
    step(4'b0000, 1'b1);
    cur = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      exp_g = 4'b0001 << o;
      for (int c = 0; c < 2; c++) begin
        step(cur, 1'b0);
        n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rotation_grant o=%0d c=%0d: got %b expected %b", o, c, grant, exp_g); end
      end
      n_checks++; if (grant_id !== 3'(o)) begin n_fail++; $display("FAIL rotation_id o=%0d: got %0d expected %0d", o, grant_id, o); end
      cur = cur & ~exp_g;
      step(cur, 1'b0);
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rotation_gap o=%0d: got %b expected 0000", o, grant); end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp_g;
    logic       exp_e;
    step(4'b0000, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      step(4'b0011, 1'b0);
      exp_g = 4'b0001;
      exp_e = 1'b0;
      if (TO_EN && c == 5) begin exp_g = 4'b0000; exp_e = 1'b1; end
      if (TO_EN && c == 6) exp_g = 4'b0010;
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL hold_grant c=%0d: got %b expected %b", c, grant, exp_g); end
      n_checks++; if (expired !== exp_e) begin n_fail++; $display("FAIL hold_expired c=%0d: got %b expected %b", c, expired, exp_e); end
    end
  endtask

  task automatic test_alone();
    step(4'b0000, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(4'b0100, 1'b0);
      n_checks++; if (grant !== 4'b0100 || expired !== 1'b0) begin n_fail++; $display("FAIL alone c=%0d: got grant=%b expired=%b expected 0100/0", c, grant, expired); end
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 0010", grant); end
    step(4'b0010, 1'b1);
    n_checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got grant=%b busy=%b expected 0000/0", grant, busy); end
    step(4'b1001, 1'b0);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_pointer: got %b expected 0001", grant); end
  endtask

  task automatic test_drop_at_limit();
    step(4'b0000, 1'b1);
    for (int c = 0; c < 4; c++) step(4'b0011, 1'b0);
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL drop_pre: got %b expected 0001", grant); end
    step(4'b0010, 1'b0);
    n_checks++; if (grant !== 4'b0000 || expired !== 1'b0) begin n_fail++; $display("FAIL drop_release: got grant=%b expired=%b expected 0000/0", grant, expired); end
    step(4'b0010, 1'b0);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL drop_next: got %b expected 0010", grant); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rs;
    step(4'b0000, 1'b1);
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      rs = ($urandom_range(0, 63) == 0);
      step(r, rs);
      n_checks++; if (grant !== m_grant()) begin n_fail++; $display("FAIL rand_grant c=%0d: got %b expected %b", c, grant, m_grant()); end
      n_checks++; if (busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, busy, m_owner >= 0); end
      n_checks++; if (expired !== m_exp) begin n_fail++; $display("FAIL rand_expired c=%0d: got %b expected %b", c, expired, m_exp); end
      if (m_owner >= 0) begin
        n_checks++; if (grant_id !== 3'(m_gid)) begin n_fail++; $display("FAIL rand_id c=%0d: got %0d expected %0d", c, grant_id, m_gid); end
      end
    end
  endtask

  initial begin
    req = 4'b0000;
    rst = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_hold_limit();
    test_alone();
    test_reset_mid();
    test_drop_at_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
